led_panel_scan_ctrl: RTL

Scan controller for the 4-row RGB LED panel. It sequences the column shift, latch, blank and row-address outputs, and fetches pixels from the frame buffer through a one-cycle-latency read port. It uses binary-coded-modulation brightness: each bit-plane of each row is shown for a time proportional to its bit weight. It sits between the frame buffer, which the UART front end writes, and the panel output pins.

---
 rtl/led_panel_scan_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_panel_scan_ctrl.sv
// rtl/led_panel_scan_ctrl.sv - 4-row RGB LED panel scan controller with binary-coded-modulation planes
module led_panel_scan_ctrl #(
    parameter int COLS       = 32,
    parameter int BITS       = 2,
    parameter int BASE_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    output logic                      fb_rd,
    output logic [1+$clog2(COLS):0]   fb_addr,
    input  logic [3*BITS-1:0]         fb_data,
    output logic                      red_out,
    output logic                      green_out,
    output logic                      blue_out,
    output logic                      sclk_out,
    output logic                      latch_out,
    output logic                      blank_out,
    output logic                      a_out,
    output logic                      b_out,
    output logic                      frame_done
);

    localparam int CW        = $clog2(COLS);
    localparam int SHIFT_LEN = 2*COLS + 2;
    localparam int SW        = $clog2(SHIFT_LEN);
    localparam int PW        = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int MAX_TICKS = BASE_TICKS << (BITS - 1);
    localparam int TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t          state;
    state_t          next_state;
    logic [1:0]      row;
    logic [PW-1:0]   plane;
    logic [SW-1:0]   s_cnt;
    logic [TW-1:0]   tick;

    logic            shift_last;
    logic            load_col;
    logic            rd_slot;
    logic            plane_last;
    logic            tick_last;
    logic [BITS-1:0] r_bits;
    logic [BITS-1:0] g_bits;
    logic [BITS-1:0] b_bits;

    assign r_bits = fb_data[BITS-1:0];
    assign g_bits = fb_data[2*BITS-1:BITS];
    assign b_bits = fb_data[3*BITS-1:2*BITS];

    // Even shift slots issue reads; the odd slot after each read captures the returned pixel.
    always_comb begin
        shift_last = (32'(s_cnt) == SHIFT_LEN - 1);
        rd_slot    = !s_cnt[0] && (32'(s_cnt) < 2*COLS);
        load_col   = s_cnt[0] && (32'(s_cnt) < 2*COLS);
        plane_last = (32'(plane) == BITS - 1);
        tick_last  = (32'(tick) == (BASE_TICKS << plane) - 1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = SHIFT;
            SHIFT:   if (shift_last) next_state = LATCH;
            LATCH:   next_state = DISPLAY;
            DISPLAY: if (tick_last) next_state = enable ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fb_rd      = 1'b0;
        fb_addr    = '0;
        sclk_out   = 1'b0;
        latch_out  = 1'b0;
        blank_out  = 1'b1;
        frame_done = 1'b0;
        case (state)
            SHIFT: begin
                fb_rd    = rd_slot;
                fb_addr  = rd_slot ? {row, s_cnt[CW:1]} : '0;
                sclk_out = s_cnt[0] && (32'(s_cnt) >= 3);
            end
            LATCH:   latch_out = 1'b1;
            DISPLAY: begin
                blank_out  = 1'b0;
                frame_done = tick_last && plane_last && (row == 2'd3);
            end
            default: ;
        endcase
    end

    // Row address pins follow the row register, which only moves on the DISPLAY exit edge.
    assign a_out = row[0];
    assign b_out = row[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            row       <= '0;
            plane     <= '0;
            s_cnt     <= '0;
            tick      <= '0;
            red_out   <= 1'b0;
            green_out <= 1'b0;
            blue_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    row   <= '0;
                    plane <= '0;
                    s_cnt <= '0;
                    tick  <= '0;
                end
                SHIFT: begin
                    s_cnt <= shift_last ? '0 : s_cnt + 1'b1;
                    if (load_col) begin
                        red_out   <= r_bits[plane];
                        green_out <= g_bits[plane];
                        blue_out  <= b_bits[plane];
                    end
                end
                LATCH: tick <= '0;
                DISPLAY: begin
                    if (tick_last) begin
                        tick <= '0;
                        if (!enable) begin
                            row   <= '0;
                            plane <= '0;
                        end else if (!plane_last) begin
                            plane <= plane + 1'b1;
                        end else begin
                            plane <= '0;
                            row   <= row + 2'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
